mem_fill_responder: RTL and testbench
=====================================

Name: mem_fill_responder

Overview:
- Main-memory side of the cache miss/fill interface: it answers the cache fill engine's word-address requests.
- Returns 16-bit words with a valid strobe after a fixed pipelined latency, accepts write-through stores, and supports an 8-word block burst.
- Sits between the I/D cache fill logic and the word-addressed backing store. The store is internal, so no external memory port is needed.

Parameters:
- LATENCY, 4, request-to-response cycles; legal range 2..8.
- MEM_WORDS, 32768, backing-store depth in 16-bit words (full 16-bit byte address space).
- BURST_LEN, 8, words per cache block; fixed at 8.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request strobe, sampled on clk rising edge
- req_wr  in  1  1 = write word, 0 = read
- req_burst  in  1  with req_wr=0: read the whole 8-word block containing req_addr
- req_addr  in  16  byte address; bit 0 ignored; word index = req_addr[15:1]
- req_wdata  in  16  write data
- busy  out  1  responder cannot accept a request this cycle
- rsp_valid  out  1  rsp_data/rsp_addr are valid this cycle
- rsp_data  out  16  read data
- rsp_addr  out  16  byte address of rsp_data, bit 0 = 0
- rsp_last  out  1  final word of a burst; 1 with every single-word read

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- On reset, all outputs are 0, the delay pipe is cleared and the FSM goes to IDLE.
- Memory contents are NOT cleared by reset.
- A request is accepted only when req_valid=1 and busy=0. Requests while busy=1 are dropped; no queueing.

Single read (req_wr=0, req_burst=0):
- Array is read at the acceptance edge and the word travels down a LATENCY-deep valid/data/addr pipe.
- rsp_valid=1 exactly LATENCY cycles after the accept edge, with rsp_last=1.
- Fully pipelined: one read per cycle; busy stays 0 in IDLE.

Write (req_wr=1):
- Array is updated at the accept edge. A read accepted on the next cycle returns the new value.
- FSM enters WRITE; busy=1 for LATENCY-1 cycles after the accept, then returns to IDLE.
- Reads already in the pipe complete normally and return their pre-write data.
- No rsp_valid is generated for a write.
- req_wr=1 with req_burst=1 is treated as a plain write.

Burst read (req_burst=1):
- FSM enters BURST and a 3-bit beat counter issues one internal word read per cycle for 8 cycles, starting with the accept cycle.
- busy=1 from the cycle after the accept until the cycle after the 8th issue.
- Responses arrive on 8 consecutive cycles, starting LATENCY cycles after the accept.
- rsp_last=1 only on the 8th response.
- Offset order is set by the optional feature below; offsets wrap within the block (offset+1 mod 8, block base = req_addr[15:4]).

FSM:
- IDLE -> WRITE on accepted write.
- IDLE -> BURST on accepted burst.
- WRITE -> IDLE when its counter reaches 0.
- BURST -> IDLE after the 8th beat.
- Returns to IDLE unconditionally on rst.

Boundaries:
- Address 0xFFFE is the last word. A burst at block 0xFFF0 reads 0xFFF0..0xFFFE with no wrap into block 0.
- A request presented on the same cycle busy deasserts is accepted.
- Reset mid-burst or mid-write: rsp_valid is 0 from the first cycle after the reset edge, and no partial beats follow.
- Pipe data from before reset is discarded.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: burst beat k returns offset (req_addr[3:1]+k) mod 8. The requested word arrives first, and the 8th beat (rsp_last) is offset req_addr[3:1]-1 mod 8.
- Undefined: bursts always return offsets 0..7 in order; req_addr[3:1] is ignored for bursts.
- Single-word reads and writes are identical in both builds.

Test Plan:
- After reset: write 0xBEEF to 0x0010; busy stays 1 for 3 cycles. Then read 0x0010 -> rsp_valid exactly 4 cycles after accept, rsp_data=0xBEEF, rsp_addr=0x0010, rsp_last=1.
- Back-to-back reads of 0x0000, 0x0002, 0x0004 on consecutive cycles (preloaded 0x1111, 0x2222, 0x3333) -> three consecutive responses in order; busy never asserted.
- Preload block 0x0040..0x004E with 0xA0..0xA7, then burst at 0x0046:
  - CRITICAL_WORD_FIRST_EN build: data A3,A4,A5,A6,A7,A0,A1,A2; rsp_last on A2.
  - Build without it: A0..A7; rsp_last on A7.
  - Both builds: a request presented during the burst is dropped.
- Read 0x0020 (old 0x5555) accepted, then write 0x0020 <- 0x6666 on the next cycle -> the response returns 0x5555. A later read returns 0x6666.
- Assert rst at burst beat 3 -> rsp_valid=0 from the next cycle onward; busy=0; a new read after reset completes with normal 4-cycle latency.
- Burst at 0xFFF8 -> 8 beats with addresses 0xFFF0..0xFFFE (order per build); no access to block 0.

Source files
------------

// File: rtl/mem_fill_if.sv
// Request/response bundle between a cache fill engine (master) and the
// main-memory responder (slave).
interface mem_fill_if;
  logic        req_valid;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_last;

  modport master (
    output req_valid, req_wr, req_burst, req_addr, req_wdata,
    input  busy, rsp_valid, rsp_data, rsp_addr, rsp_last
  );

  modport slave (
    input  req_valid, req_wr, req_burst, req_addr, req_wdata,
    output busy, rsp_valid, rsp_data, rsp_addr, rsp_last
  );
endinterface

// File: rtl/mem_fill_responder.sv
// Main-memory responder for cache fills: pipelined single reads, write-through stores and
// 8-word block bursts. Define CRITICAL_WORD_FIRST_EN to return the requested word first.
module mem_fill_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_WORDS = 32768,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic      clk,
  input  logic      rst,
  mem_fill_if.slave bus
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StBurst
  } stateE;

  stateE       stateQ, stateD;
  logic [2:0]  cntQ, cntD;
  logic [2:0]  beatQ, beatD;
  logic [11:0] baseQ, baseD;
  logic [2:0]  burstOff;
`ifdef CRITICAL_WORD_FIRST_EN
  logic [2:0]  startQ, startD;
`endif

  logic        accept;
  logic        wrEn;
  logic        issueRd;
  logic        issueLast;
  logic [15:0] issueAddr;

  logic [15:0] mem [MEM_WORDS];

  logic [LATENCY-1:0] pValidQ;
  logic [LATENCY-1:0] pLastQ;
  logic [15:0]        pAddrQ [LATENCY];
  logic [15:0]        pDataQ [LATENCY];

`ifdef CRITICAL_WORD_FIRST_EN
  assign burstOff = startQ + beatQ;
`else
  assign burstOff = beatQ;
`endif

  assign bus.busy = (stateQ != StIdle);

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    beatD     = beatQ;
    baseD     = baseQ;
`ifdef CRITICAL_WORD_FIRST_EN
    startD    = startQ;
`endif
    wrEn      = 1'b0;
    issueRd   = 1'b0;
    issueLast = 1'b0;
    issueAddr = '0;
    accept    = bus.req_valid && (stateQ == StIdle);

    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          if (bus.req_wr) begin
            wrEn   = 1'b1;
            stateD = StWrite;
            cntD   = 3'(LATENCY - 2);
          end else if (bus.req_burst) begin
            // Beat 0 is issued on the accept edge itself.
            issueRd = 1'b1;
            baseD   = bus.req_addr[15:4];
            beatD   = 3'd1;
            stateD  = StBurst;
`ifdef CRITICAL_WORD_FIRST_EN
            startD    = bus.req_addr[3:1];
            issueAddr = {bus.req_addr[15:4], bus.req_addr[3:1], 1'b0};
`else
            issueAddr = {bus.req_addr[15:4], 3'd0, 1'b0};
`endif
          end else begin
            issueRd   = 1'b1;
            issueLast = 1'b1;
            issueAddr = bus.req_addr & 16'hFFFE;
          end
        end
      end
      StWrite: begin
        if (cntQ == 3'd0) begin
          stateD = StIdle;
        end else begin
          cntD = cntQ - 3'd1;
        end
      end
      StBurst: begin
        issueRd   = 1'b1;
        issueAddr = {baseQ, burstOff, 1'b0};
        issueLast = (beatQ == 3'(BURST_LEN - 1));
        beatD     = beatQ + 3'd1;
        if (issueLast) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      beatQ  <= '0;
      baseQ  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      startQ <= '0;
`endif
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      beatQ  <= beatD;
      baseQ  <= baseD;
`ifdef CRITICAL_WORD_FIRST_EN
      startQ <= startD;
`endif
    end
  end

  // Backing store and data pipe; contents survive reset, stale data is masked by pValidQ.
  always_ff @(posedge clk) begin
    if (wrEn && !rst) begin
      mem[bus.req_addr[IdxW:1]] <= bus.req_wdata;
    end
    pDataQ[0] <= mem[issueAddr[IdxW:1]];
    for (int i = 1; i < LATENCY; i++) begin
      pDataQ[i] <= pDataQ[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pValidQ       <= '0;
      pLastQ        <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pAddrQ[i] <= '0;
      end
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_addr  <= '0;
    end else begin
      pValidQ   <= {pValidQ[LATENCY-2:0], issueRd};
      pLastQ    <= {pLastQ[LATENCY-2:0], issueLast};
      pAddrQ[0] <= issueAddr;
      for (int i = 1; i < LATENCY; i++) begin
        pAddrQ[i] <= pAddrQ[i-1];
      end
      bus.rsp_valid <= pValidQ[LATENCY-1];
      bus.rsp_last  <= pValidQ[LATENCY-1] & pLastQ[LATENCY-1];
      bus.rsp_data  <= pValidQ[LATENCY-1] ? pDataQ[LATENCY-1] : 16'h0000;
      bus.rsp_addr  <= pValidQ[LATENCY-1] ? pAddrQ[LATENCY-1] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder (LATENCY=4); expectations follow
// CRITICAL_WORD_FIRST_EN when it is defined for the build.
module tb_mem_fill_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_fill_if bus ();

  mem_fill_responder #(
    .LATENCY  (4),
    .MEM_WORDS(32768),
    .BURST_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleReq();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_burst = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 32) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, required 0 within 32 cycles", bus.busy);
    end
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
    waitIdle();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_burst = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    idleReq();
  endtask

  task automatic startRead(input logic [15:0] a, input logic burst);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_burst = burst;
    bus.req_addr  = a;
    tick();
    idleReq();
  endtask

  task automatic test_reset();
    logic [34:0] got;
    rst = 1'b1;
    idleReq();
    repeat (3) tick();
    got = {bus.busy, bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
    rst = 1'b0;
    tick();
    got = {bus.busy, bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h required 0", got);
    end
  endtask

  task automatic test_write_read();
    logic [33:0] got;
    doWrite(16'h0010, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL write_busy[%0d]: busy=%b rsp_valid=%b required 1/0", i, bus.busy,
                 bus.rsp_valid);
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_release: busy=%b required 0", bus.busy);
    end
    startRead(16'h0010, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL read_early[%0d]: rsp_valid=%b required 0", i, bus.rsp_valid);
      end
    end
    tick();
    got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== {1'b1, 1'b1, 16'hBEEF, 16'h0010}) begin
      errors++;
      $display("FAIL read_beef: got %h required %h", got, {1'b1, 1'b1, 16'hBEEF, 16'h0010});
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_single_pulse: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] got, exp;
    logic [15:0] vals [3];
    vals[0] = 16'h1111;
    vals[1] = 16'h2222;
    vals[2] = 16'h3333;
    for (int i = 0; i < 3; i++) doWrite(16'(2 * i), vals[i]);
    waitIdle();
    for (int i = 0; i < 3; i++) begin
      startRead(16'(2 * i), 1'b0);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy[%0d]: busy=%b required 0", i, bus.busy);
      end
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early: rsp_valid=%b required 0", bus.rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
      exp = {1'b1, 1'b1, vals[i], 16'(2 * i)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: got %h required %h", i, got, exp);
      end
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_burst();
    logic [33:0] got, exp;
    logic [2:0]  off;
    for (int i = 0; i < 8; i++) doWrite(16'h0040 + 16'(2 * i), 16'h00A0 + 16'(i));
    waitIdle();
    startRead(16'h0046, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_busy: busy=%b required 1", bus.busy);
    end
    // A write presented while busy must be dropped.
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 16'h0040;
    bus.req_wdata = 16'hDEAD;
    tick();
    idleReq();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL burst_early[%0d]: rsp_valid=%b required 0", i, bus.rsp_valid);
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef CRITICAL_WORD_FIRST_EN
      off = 3'(3 + k);
`else
      off = 3'(k);
`endif
      got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
      exp = {1'b1, (k == 7), 16'h00A0 + 16'(off), 16'h0040 + 16'({off, 1'b0})};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL burst_beat[%0d]: got %h required %h", k, got, exp);
      end
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: rsp_valid=%b busy=%b required 0/0", bus.rsp_valid, bus.busy);
    end
    startRead(16'h0040, 1'b0);
    repeat (4) tick();
    got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== {1'b1, 1'b1, 16'h00A0, 16'h0040}) begin
      errors++;
      $display("FAIL burst_dropped_write: got %h required %h", got,
               {1'b1, 1'b1, 16'h00A0, 16'h0040});
    end
  endtask

  task automatic test_read_write_hazard();
    logic [33:0] got;
    doWrite(16'h0020, 16'h5555);
    waitIdle();
    startRead(16'h0020, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_wdata = 16'h6666;
    tick();
    idleReq();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_write_accept: busy=%b required 1", bus.busy);
    end
    repeat (3) tick();
    got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== {1'b1, 1'b1, 16'h5555, 16'h0020}) begin
      errors++;
      $display("FAIL hazard_old: got %h required %h", got, {1'b1, 1'b1, 16'h5555, 16'h0020});
    end
    waitIdle();
    startRead(16'h0020, 1'b0);
    repeat (4) tick();
    got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== {1'b1, 1'b1, 16'h6666, 16'h0020}) begin
      errors++;
      $display("FAIL hazard_new: got %h required %h", got, {1'b1, 1'b1, 16'h6666, 16'h0020});
    end
  endtask

  task automatic test_reset_midburst();
    logic [34:0] got;
    logic [33:0] rsp;
    waitIdle();
    startRead(16'h0040, 1'b1);
    repeat (5) tick();
    // Burst from offset 0 is identical in both builds: beat 1 is 0x00A1 at 0x0042.
    got = {bus.busy, bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 16'h00A1, 16'h0042}) begin
      errors++;
      $display("FAIL midburst_pre: got %h required %h", got,
               {1'b1, 1'b1, 1'b0, 16'h00A1, 16'h0042});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: rsp_valid=%b busy=%b required 0/0", bus.rsp_valid, bus.busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midburst_residue[%0d]: rsp_valid=%b required 0", i, bus.rsp_valid);
      end
    end
    startRead(16'h0046, 1'b0);
    repeat (3) tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midburst_after_early: rsp_valid=%b required 0", bus.rsp_valid);
    end
    tick();
    rsp = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
    checks++;
    if (rsp !== {1'b1, 1'b1, 16'h00A3, 16'h0046}) begin
      errors++;
      $display("FAIL midburst_after: got %h required %h", rsp, {1'b1, 1'b1, 16'h00A3, 16'h0046});
    end
  endtask

  task automatic test_burst_top();
    logic [33:0] got, exp;
    logic [2:0]  off;
    for (int i = 0; i < 8; i++) doWrite(16'hFFF0 + 16'(2 * i), 16'hF000 + 16'(i));
    waitIdle();
    startRead(16'hFFF8, 1'b1);
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef CRITICAL_WORD_FIRST_EN
      off = 3'(4 + k);
`else
      off = 3'(k);
`endif
      got = {bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.rsp_addr};
      exp = {1'b1, (k == 7), 16'hF000 + 16'(off), 16'hFFF0 + 16'({off, 1'b0})};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL top_beat[%0d]: got %h required %h", k, got, exp);
      end
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL top_tail: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  initial begin
    idleReq();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_burst();
    test_read_write_hazard();
    test_reset_midburst();
    test_burst_top();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
